// File: rtl/line_xfer_pkg.sv
// Shared types and constants for the cache-line quad-SPI transfer engine.
package line_xfer_pkg;

    // Transfer FSM states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB_LOAD = 3'd1,
        S_CMD     = 3'd2,
        S_ADDR    = 3'd3,
        S_DUMMY   = 3'd4,
        S_DATA    = 3'd5,
        S_FILL    = 3'd6,
        S_END     = 3'd7
    } state_t;

    // Flash/PSRAM quad command opcodes.
    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;

    // Phase lengths. CMD/ADDR/DATA are in 2-cycle slots, END is in cycles.
    localparam int CMD_SLOTS    = 2;
    localparam int ADDR_SLOTS   = 6;
    localparam int DATA_SLOTS   = 8;
    localparam int END_CYCLES   = 2;

    // A cache line is 8 nibbles (32 bits).
    localparam int LINE_NIBBLES = 8;
    localparam int LINE_BITS    = 4 * LINE_NIBBLES;

    // Nibble idx of a 24-bit address, counting from the most significant nibble.
    function automatic logic [3:0] addr_nibble(input logic [23:0] addr, input logic [2:0] idx);
        logic [23:0] shifted;
        shifted = addr << {idx, 2'b00};
        return shifted[23:20];
    endfunction

endpackage

// File: rtl/line_xfer_buf.sv
// 32-bit nibble shift register holding one cache line. Nibble 0 enters first
// and ends up at the top, so shifting in and shifting out both move left and
// the outgoing nibble is always the top one.
module line_buf
    import line_xfer_pkg::*;
(
    input  logic       clk,
    input  logic       i_in_en,
    input  logic [3:0] i_in_nibble,
    input  logic       i_out_en,
    output logic [3:0] o_out_nibble
);

    logic [LINE_BITS-1:0] r_line;

    // Shift a nibble in at the bottom, or advance the output by one nibble.
    always_ff @(posedge clk) begin
        if (i_in_en) begin
            r_line <= {r_line[LINE_BITS-5:0], i_in_nibble};
        end else if (i_out_en) begin
            r_line <= {r_line[LINE_BITS-5:0], 4'h0};
        end
    end

    assign o_out_nibble = r_line[LINE_BITS-1:LINE_BITS-4];

endmodule

// File: rtl/line_xfer.sv
// Moves one 32-bit cache line between the cache and a quad-SPI flash/PSRAM.
// Writeback: collect 8 nibbles from the cache, then CMD/ADDR/DATA on the bus.
// Fill: CMD/ADDR/DUMMY/DATA on the bus, then stream 8 nibbles to the cache.
// Cache-side handshake: o_wb_strobe / o_fill_strobe are pure strobes, each
// burst exactly 8 back-to-back cycles; a nibble moves on every strobe cycle
// with no back-pressure, and the cache restarts its count on any idle cycle.
module line_xfer
    import line_xfer_pkg::*;
#(
    parameter int PA    = 22,
    parameter int DUMMY = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pull,
    input  logic [PA-3:0] i_tag,
    output logic [3:0]    o_fill_nibble,
    output logic          o_fill_strobe,
    input  logic [3:0]    i_wb_nibble,
    output logic          o_wb_strobe,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_qspi_cs_n,
    output logic          o_qspi_sck,
    output logic [3:0]    o_qspi_io_out,
    output logic [3:0]    o_qspi_io_oe,
    input  logic [3:0]    i_qspi_io_in,
    output logic [2:0]    o_state
);

    // Counter must hold the longest phase: DATA (16 cycles) or DUMMY.
    localparam int CNT_LEN = (2 * DUMMY > 2 * DATA_SLOTS) ? 2 * DUMMY : 2 * DATA_SLOTS;
    localparam int CW      = $clog2(CNT_LEN);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_len_m1;
    logic            w_last;
    logic            w_phase;
    logic [2:0]      w_slot;
    logic            r_is_write;
    logic [PA-3:0]   r_tag;
    logic [23:0]     w_addr;
    logic [7:0]      w_cmd;
    logic            w_buf_in_en;
    logic [3:0]      w_buf_in_nib;
    logic            w_buf_out_en;
    logic [3:0]      w_buf_out_nib;

    assign w_phase = r_cnt[0];
    assign w_slot  = r_cnt[3:1];
    assign w_last  = (r_cnt == w_len_m1);
    assign w_addr  = 24'({r_tag, 2'b00});
    assign w_cmd   = r_is_write ? CMD_WRITE : CMD_READ;
    assign o_busy  = (r_state != S_IDLE);
    assign o_state = r_state;

    // State register and in-state cycle counter; counter restarts on every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_IDLE) begin
                r_is_write <= i_push;
            end
        end
    end

    // Latch the line address when a request is accepted; later tag changes are ignored.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && (i_push || i_pull)) begin
            r_tag <= i_tag;
        end
    end

    // Last counter value of each state, in clk cycles.
    always_comb begin
        w_len_m1 = '0;
        case (r_state)
            S_WB_LOAD: w_len_m1 = CW'(LINE_NIBBLES - 1);
            S_CMD:     w_len_m1 = CW'(2 * CMD_SLOTS - 1);
            S_ADDR:    w_len_m1 = CW'(2 * ADDR_SLOTS - 1);
            S_DUMMY:   w_len_m1 = CW'(2 * DUMMY - 1);
            S_DATA:    w_len_m1 = CW'(2 * DATA_SLOTS - 1);
            S_FILL:    w_len_m1 = CW'(LINE_NIBBLES - 1);
            S_END:     w_len_m1 = CW'(END_CYCLES - 1);
            default:   w_len_m1 = '0;
        endcase
    end

    // Next-state decode and all outputs as a function of state and counter.
    always_comb begin
        w_next        = r_state;
        o_qspi_cs_n   = 1'b1;
        o_qspi_sck    = 1'b0;
        o_qspi_io_oe  = 4'h0;
        o_qspi_io_out = 4'h0;
        o_fill_strobe = 1'b0;
        o_fill_nibble = 4'h0;
        o_wb_strobe   = 1'b0;
        o_done        = 1'b0;
        w_buf_in_en   = 1'b0;
        w_buf_in_nib  = 4'h0;
        w_buf_out_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_push) begin
                    w_next = S_WB_LOAD;
                end else if (i_pull) begin
                    w_next = S_CMD;
                end
            end
            S_WB_LOAD: begin
                o_wb_strobe  = 1'b1;
                w_buf_in_en  = 1'b1;
                w_buf_in_nib = i_wb_nibble;
                if (w_last) w_next = S_CMD;
            end
            S_CMD: begin
                o_qspi_cs_n   = 1'b0;
                o_qspi_sck    = w_phase;
                o_qspi_io_oe  = 4'hF;
                o_qspi_io_out = w_slot[0] ? w_cmd[3:0] : w_cmd[7:4];
                if (w_last) w_next = S_ADDR;
            end
            S_ADDR: begin
                o_qspi_cs_n   = 1'b0;
                o_qspi_sck    = w_phase;
                o_qspi_io_oe  = 4'hF;
                o_qspi_io_out = addr_nibble(w_addr, w_slot);
                if (w_last) begin
                    if (r_is_write || DUMMY == 0) w_next = S_DATA;
                    else                          w_next = S_DUMMY;
                end
            end
            S_DUMMY: begin
                o_qspi_cs_n = 1'b0;
                o_qspi_sck  = w_phase;
                if (w_last) w_next = S_DATA;
            end
            S_DATA: begin
                o_qspi_cs_n = 1'b0;
                o_qspi_sck  = w_phase;
                if (r_is_write) begin
                    // Next nibble is presented at the start of the following slot.
                    o_qspi_io_oe  = 4'hF;
                    o_qspi_io_out = w_buf_out_nib;
                    w_buf_out_en  = w_phase;
                end else begin
                    // Sample at the clk edge that ends the high sck phase.
                    w_buf_in_en  = w_phase;
                    w_buf_in_nib = i_qspi_io_in;
                end
                if (w_last) w_next = r_is_write ? S_END : S_FILL;
            end
            S_FILL: begin
                o_fill_strobe = 1'b1;
                o_fill_nibble = w_buf_out_nib;
                w_buf_out_en  = 1'b1;
                if (w_last) w_next = S_END;
            end
            S_END: begin
                if (w_last) begin
                    o_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    line_buf u_line_buf (
        .clk          (clk),
        .i_in_en      (w_buf_in_en),
        .i_in_nibble  (w_buf_in_nib),
        .i_out_en     (w_buf_out_en),
        .o_out_nibble (w_buf_out_nib)
    );

endmodule

// File: tb/tb_line_xfer.sv
// Directed bench for line_xfer: stimulus pushes expected bus slots, fill
// nibbles and done cycles into queues; a negedge monitor pops and compares.
module tb_line_xfer;

  localparam int PA_B    = 22;
  localparam int DUMMY_B = 6;

  logic            clk;
  logic            reset;
  logic            push;
  logic            pull;
  logic [PA_B-3:0] tag;
  logic [3:0]      fill_nibble;
  logic            fill_strobe;
  logic [3:0]      wb_nibble;
  logic            wb_strobe;
  logic            busy;
  logic            done;
  logic            qspi_cs_n;
  logic            qspi_sck;
  logic [3:0]      qspi_io_out;
  logic [3:0]      qspi_io_oe;
  logic [3:0]      qspi_io_in;
  logic [2:0]      state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_bus_q[$];
  logic [3:0] exp_fill_q[$];
  int         exp_done_q[$];
  logic [3:0] flash_q[$];
  logic [3:0] wb_src_q[$];

  line_xfer #(.PA(PA_B), .DUMMY(DUMMY_B)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_push        (push),
    .i_pull        (pull),
    .i_tag         (tag),
    .o_fill_nibble (fill_nibble),
    .o_fill_strobe (fill_strobe),
    .i_wb_nibble   (wb_nibble),
    .o_wb_strobe   (wb_strobe),
    .o_busy        (busy),
    .o_done        (done),
    .o_qspi_cs_n   (qspi_cs_n),
    .o_qspi_sck    (qspi_sck),
    .o_qspi_io_out (qspi_io_out),
    .o_qspi_io_oe  (qspi_io_oe),
    .i_qspi_io_in  (qspi_io_in),
    .o_state       (state)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver helpers: expected bus slots as {oe, io_out}
  task automatic exp_cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    exp_bus_q.push_back({4'hF, cmd[7:4]});
    exp_bus_q.push_back({4'hF, cmd[3:0]});
    for (int i = 0; i < 6; i++) exp_bus_q.push_back({4'hF, addr[23-4*i -: 4]});
  endtask

  task automatic exp_hiz(input int n);
    for (int i = 0; i < n; i++) exp_bus_q.push_back(8'h00);
  endtask

  task automatic exp_read_data(input logic [31:0] line);
    for (int i = 0; i < 8; i++) begin
      flash_q.push_back(line[31-4*i -: 4]);
      exp_fill_q.push_back(line[31-4*i -: 4]);
    end
  endtask

  task automatic exp_write_data(input logic [31:0] line);
    for (int i = 0; i < 8; i++) begin
      wb_src_q.push_back(line[31-4*i -: 4]);
      exp_bus_q.push_back({4'hF, line[31-4*i -: 4]});
    end
  endtask

  task automatic wait_idle(input int n);
    int k;
    k = 0;
    while (busy && k < n) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: got busy=1 expected idle within %0d cycles", n);
    end
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (!done && k < n) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_done: got no done expected within %0d cycles", n);
    end
  endtask

  // scoreboard monitor: bus slots, flash model, wb source, fill and done
  initial begin
    int         bus_slot;
    int         wb_run;
    int         fill_run;
    logic [7:0] eb;
    logic [3:0] ef;
    int         ed;
    bus_slot   = 0;
    wb_run     = 0;
    fill_run   = 0;
    qspi_io_in = 4'h0;
    wb_nibble  = 4'h0;
    forever begin
      @(negedge clk);
      if (qspi_cs_n !== 1'b0) begin
        bus_slot = 0;
      end else if (qspi_sck === 1'b1) begin
        if (exp_bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected: got slot %0d {oe,io}=%0h expected none", bus_slot, {qspi_io_oe, qspi_io_out});
        end else begin
          eb = exp_bus_q.pop_front();
          chk($sformatf("bus_slot%0d", bus_slot), {24'h0, qspi_io_oe, qspi_io_out}, {24'h0, eb});
        end
        if (qspi_io_oe == 4'h0 && bus_slot >= 2 + 6 + DUMMY_B) begin
          if (flash_q.size() > 0) qspi_io_in = flash_q.pop_front();
          else                    qspi_io_in = 4'h0;
        end else begin
          qspi_io_in = 4'h9;
        end
        bus_slot++;
      end
      if (wb_strobe === 1'b1) begin
        wb_run++;
        if (wb_src_q.size() > 0) begin
          wb_nibble = wb_src_q.pop_front();
        end else begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected: got wb_strobe expected none");
        end
      end else if (wb_run > 0) begin
        chk("wb_burst_len", wb_run, 8);
        wb_run = 0;
      end
      if (fill_strobe === 1'b1) begin
        fill_run++;
        if (exp_fill_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fill_unexpected: got nibble %0h expected none", fill_nibble);
        end else begin
          ef = exp_fill_q.pop_front();
          chk("fill_nibble", {28'h0, fill_nibble}, {28'h0, ef});
        end
      end else if (fill_run > 0) begin
        chk("fill_burst_len", fill_run, 8);
        fill_run = 0;
      end
      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: got done at %0d expected none", cyc);
        end else begin
          ed = exp_done_q.pop_front();
          chk("done_cycle", cyc, ed);
        end
      end
    end
  end

  // stimulus
  initial begin
    reset = 1'b1;
    push  = 1'b0;
    pull  = 1'b0;
    tag   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", qspi_cs_n, 1);
    chk("rst_sck", qspi_sck, 0);
    chk("rst_oe", qspi_io_oe, 0);
    chk("rst_io_out", qspi_io_out, 0);
    chk("rst_fill_strobe", fill_strobe, 0);
    chk("rst_wb_strobe", wb_strobe, 0);
    chk("rst_fill_nibble", fill_nibble, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state, 0);
    reset = 1'b0;
    @(negedge clk);

    // read, tag 12345 -> addr 048D14, flash 1..8, done at cycle 55
    exp_cmd_addr(8'hEB, 24'h048D14);
    exp_hiz(DUMMY_B + 8);
    exp_read_data(32'h12345678);
    exp_done_q.push_back(cyc + 54);
    pull = 1'b1;
    tag  = 20'h12345;
    @(negedge clk);
    pull = 1'b0;
    wait_idle(200);
    @(negedge clk);

    // write, tag 00001 -> addr 000004, wb A..1, done at cycle 43
    exp_cmd_addr(8'h38, 24'h000004);
    exp_write_data(32'hABCDEF01);
    exp_done_q.push_back(cyc + 42);
    push = 1'b1;
    tag  = 20'h00001;
    @(negedge clk);
    push = 1'b0;
    wait_idle(200);
    @(negedge clk);

    // push and pull together: write first, read sampled in the IDLE cycle after END
    exp_cmd_addr(8'h38, 24'h02AF34);
    exp_write_data(32'h56789ABC);
    exp_cmd_addr(8'hEB, 24'h02AF34);
    exp_hiz(DUMMY_B + 8);
    exp_read_data(32'hFEDCBA98);
    exp_done_q.push_back(cyc + 42);
    exp_done_q.push_back(cyc + 97);
    push = 1'b1;
    pull = 1'b1;
    tag  = 20'h0ABCD;
    @(negedge clk);
    push = 1'b0;
    wait_done(100);
    @(negedge clk);
    chk("gap_busy", busy, 0);
    chk("gap_cs_n", qspi_cs_n, 1);
    @(negedge clk);
    chk("read2_busy", busy, 1);
    chk("read2_cs_n", qspi_cs_n, 0);
    pull = 1'b0;
    wait_idle(200);
    @(negedge clk);

    // reset in the 3rd DATA slot of a read (cycle 34, phase 0)
    exp_cmd_addr(8'hEB, 24'h000400);
    exp_hiz(DUMMY_B + 2);
    flash_q.push_back(4'h3);
    flash_q.push_back(4'hC);
    pull = 1'b1;
    tag  = 20'h00100;
    @(negedge clk);
    pull = 1'b0;
    repeat (32) @(negedge clk);
    chk("pre_rst_state", state, 5);
    chk("pre_rst_sck", qspi_sck, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_cs_n", qspi_cs_n, 1);
    chk("abort_oe", qspi_io_oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fill_strobe", fill_strobe, 0);
    chk("abort_bus_q_empty", exp_bus_q.size(), 0);
    chk("abort_flash_q_empty", flash_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("abort_still_idle", busy, 0);

    // clean read after abort, tag 3FFFF -> addr 0FFFFC
    exp_cmd_addr(8'hEB, 24'h0FFFFC);
    exp_hiz(DUMMY_B + 8);
    exp_read_data(32'h24681357);
    exp_done_q.push_back(cyc + 54);
    pull = 1'b1;
    tag  = 20'h3FFFF;
    @(negedge clk);
    pull = 1'b0;
    wait_idle(200);
    @(negedge clk);

    // one-cycle pull, tag changed next cycle: latched tag 0F0F0 -> addr 03C3C0
    exp_cmd_addr(8'hEB, 24'h03C3C0);
    exp_hiz(DUMMY_B + 8);
    exp_read_data(32'h87654321);
    exp_done_q.push_back(cyc + 54);
    pull = 1'b1;
    tag  = 20'h0F0F0;
    @(negedge clk);
    pull = 1'b0;
    tag  = 20'hFFFFF;
    wait_idle(200);

    repeat (5) @(negedge clk);
    chk("end_bus_q_empty", exp_bus_q.size(), 0);
    chk("end_fill_q_empty", exp_fill_q.size(), 0);
    chk("end_done_q_empty", exp_done_q.size(), 0);
    chk("end_flash_q_empty", flash_q.size(), 0);
    chk("end_wb_src_q_empty", wb_src_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_xfer.md
LINE_XFER -- requirements
Module: line_xfer

Interface
REQ-001 Parameter PA, default 22, physical byte-address width.
REQ-002 Parameter DUMMY, default 6, read turnaround slots (mode plus dummy) after the address.
REQ-003 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 push  in  1  cache requests a writeback of a dirty line; pull  in  1  cache requests a line fill.
REQ-005 tag  in  PA-2  line address [PA-1:2] of the line to write back or fill.
REQ-006 fill_nibble  out  4  fill data to the cache; fill_strobe  out  1  fill_nibble valid this cycle (cache-side wstrobe_d).
REQ-007 wb_nibble  in  4  writeback data from the cache; wb_strobe  out  1  request and consume wb_nibble this cycle (cache-side rstrobe_d).
REQ-008 busy  out  1  transaction in progress; done  out  1  one-cycle completion pulse.
REQ-009 qspi_cs_n  out  1; qspi_sck  out  1; qspi_io_out  out  4; qspi_io_oe  out  4; qspi_io_in  in  4  quad-SPI flash/PSRAM pins.

Function
REQ-010 Line = 8 nibbles; nibble order is fixed: byte0[7:4], byte0[3:0], byte1[7:4], ..., byte3[3:0], on both the cache side and the qspi side.
REQ-011 States: IDLE, WB_LOAD, CMD, ADDR, DUMMY, DATA, FILL, END.
REQ-012 push and pull are sampled in IDLE only. If push=1, the next state is WB_LOAD (write). Otherwise, if pull=1, the next state is CMD (read). tag is latched on that cycle.
REQ-013 If push and pull are both asserted, push wins; pull is re-sampled once the block is back in IDLE.
REQ-014 WB_LOAD: wb_strobe is held high for exactly 8 consecutive cycles; wb_nibble is captured into an internal 32-bit line buffer in the same cycle, in REQ-010 order. The block then enters CMD.
REQ-015 The cache-side strobes (fill_strobe, wb_strobe) are never gapped; each burst is exactly 8 back-to-back cycles, because the cache resets its nibble counter on any strobe-free cycle.
REQ-016 A slot is 2 clk cycles:
- phase 0: qspi_sck=0, io_out updated;
- phase 1: qspi_sck=1, qspi_io_in sampled at the clk edge that ends phase 1.
REQ-017 qspi_cs_n goes low on the first CMD cycle and stays low through DATA.
REQ-018 CMD: 2 slots carrying the command byte, high nibble first: 0xEB for a read, 0x38 for a write. qspi_io_oe=4'hF.
REQ-019 ADDR: 6 slots carrying the 24-bit address {zero-extend, tag, 2'b00}, MSB nibble first. qspi_io_oe=4'hF.
REQ-020 DUMMY is entered for reads only: DUMMY slots with qspi_io_oe=4'h0. Writes go from ADDR directly to DATA.
REQ-021 DATA, write: 8 slots driving the line buffer with qspi_io_oe=4'hF. DATA, read: 8 slots with qspi_io_oe=4'h0, each sampled nibble shifted into the line buffer.
REQ-022 After DATA, a read enters FILL: fill_strobe is high for 8 consecutive cycles with fill_nibble = buffer nibbles 0..7. A write enters END directly.
REQ-023 FILL is followed by END. END holds qspi_cs_n=1 and qspi_sck=0 for 2 cycles, then returns to IDLE.
REQ-024 done is pulsed for one cycle on the last END cycle. busy=0 only in IDLE.
REQ-025 Latency from request sample to done, with DUMMY=6: read = 2×(2+6+6+8) + 8 + 2 + 1 = 55 cycles; write = 8 + 2×(2+6+8) + 2 + 1 = 43 cycles.
REQ-026 Deassertion of push, pull or tag changes after the request is sampled are ignored; the transaction always completes.
REQ-027 Slot and nibble counters saturate into the next state transition only; no wrap-around is visible on the outputs.
REQ-028 qspi_io_out = 4'h0 whenever qspi_io_oe = 4'h0. fill_nibble is a don't-care outside FILL, but is driven as 4'h0.

Reset
REQ-029 Reset leads to IDLE on the next clk edge, including mid-transaction. The line buffer and latched tag are not reset.
REQ-030 Reset values of the outputs:
- qspi_cs_n=1, qspi_sck=0;
- qspi_io_oe=0, qspi_io_out=0;
- fill_strobe=0, wb_strobe=0, fill_nibble=0;
- busy=0, done=0.

Structure
REQ-031 Package line_xfer_pkg holds:
- the state enum;
- CMD_READ=8'hEB and CMD_WRITE=8'h38;
- the slot counts CMD_SLOTS=2, ADDR_SLOTS=6, DATA_SLOTS=8, END_CYCLES=2.
REQ-032 The line buffer is one sub-module, line_buf: a 32-bit nibble shift register with a load-shift-in port and a shift-out port, and no other state.

Verification
REQ-033 pull=1, tag=20'h12345, flash returns nibbles 1..8 → bus carries cmd EB, address nibbles 0,4,8,D,1,4, six hi-Z slots, then fill_nibble 1,2,...,8 on 8 consecutive fill_strobe cycles; done at cycle 55.
REQ-034 push=1, tag=20'h00001, wb_nibble sequence A,B,C,D,E,F,0,1 → 8 consecutive wb_strobe cycles, then cmd 38 and address nibbles 0,0,0,0,0,4, with data A..1 driven and oe=F; done at cycle 43.
REQ-035 push=1 and pull=1 in the same cycle → write performed first; pull held high → read starts 1 cycle after END.
REQ-036 Reset asserted in the 3rd DATA slot of a read → next cycle cs_n=1, oe=0, busy=0, no fill_strobe; a following pull performs a clean read.
REQ-037 pull pulsed for 1 cycle with tag changed the next cycle → full read using the originally latched tag.
